// File: rtl/lsu_byte_sequencer_pkg.sv
// Shared types and helpers for the byte-serial load/store sequencer.
// Size codes follow the core's DMCtrl encoding.
package lsu_pkg;

   typedef enum logic [2:0] {
      SZ_B  = 3'b000,
      SZ_H  = 3'b001,
      SZ_W  = 3'b010,
      SZ_BU = 3'b100,
      SZ_HU = 3'b101
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_XFER,
      ST_RESP
   } state_e;

   function automatic logic [2:0] size_to_bytes(input logic [2:0] code);
      logic [2:0] n;
      case (code)
         SZ_H, SZ_HU: n = 3'd2;
         SZ_W:        n = 3'd4;
         default:     n = 3'd1;
      endcase
      return n;
   endfunction

   // Unsigned sizes only make sense for loads, so a store with BU/HU is rejected.
   function automatic logic size_valid(input logic [2:0] code, input logic wr);
      logic ok;
      case (code)
         SZ_B, SZ_H, SZ_W: ok = 1'b1;
         SZ_BU, SZ_HU:     ok = !wr;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] data, input logic [2:0] code);
      logic [31:0] res;
      case (code)
         SZ_B:    res = {{24{data[7]}}, data[7:0]};
         SZ_H:    res = {{16{data[15]}}, data[15:0]};
         SZ_BU:   res = {24'h000000, data[7:0]};
         SZ_HU:   res = {16'h0000, data[15:0]};
         default: res = data;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsu_byte_sequencer_if.sv
// Request/response handshake plus byte-wide memory port of the sequencer.
// slave is the sequencer's view; master is the core/memory side.
interface lsu_byte_sequencer_if #(
   parameter int MEM_AW = 5
);
   logic              req_valid;
   logic              req_ready;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              req_DMWR;
   logic [2:0]        req_DMCtrl;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_data;
   logic              resp_err;
   logic [MEM_AW-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport slave (
      input  req_valid, req_addr, req_wdata, req_DMWR, req_DMCtrl, resp_ready, mem_rdata,
      output req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output req_valid, req_addr, req_wdata, req_DMWR, req_DMCtrl, resp_ready, mem_rdata,
      input  req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/lsu_byte_sequencer_load_extend.sv
// Turns the little-endian assembly register into the sign/zero-extended load result.
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] asm_i,
   input  logic [2:0]  code_i,
   output logic [31:0] data_o
);

   assign data_o = extend(asm_i, code_i);

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Splits one load/store into 1/2/4 sequential byte accesses, lowest address first.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses instead of sequencing them.
module lsu_byte_sequencer
   import lsu_pkg::*;
#(
   parameter int MEM_DEPTH = 21,
   parameter int MEM_AW    = 5
) (
   input logic                 clk,
   input logic                 rst,
   lsu_byte_sequencer_if.slave bus
);

   state_e            state_q, state_d;
   logic [MEM_AW-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic [2:0]        n_q, n_d;
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       asm_q, asm_d;
   logic              err_q, err_d;

   logic [2:0]  reqN;
   logic [32:0] lastAddr;
   logic        reqErr;
   logic [31:0] extData;

   assign reqN = size_to_bytes(bus.req_DMCtrl);
   // 33-bit sum so a request wrapping past 0xFFFFFFFF is treated as out of range.
   assign lastAddr = {1'b0, bus.req_addr} + 33'(reqN) - 33'd1;

`ifdef LSU_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = ((reqN == 3'd2) && bus.req_addr[0]) ||
                       ((reqN == 3'd4) && (bus.req_addr[1:0] != 2'b00));
   assign reqErr = !size_valid(bus.req_DMCtrl, bus.req_DMWR) || misaligned ||
                   (lastAddr >= 33'(MEM_DEPTH));
`else
   assign reqErr = !size_valid(bus.req_DMCtrl, bus.req_DMWR) ||
                   (lastAddr >= 33'(MEM_DEPTH));
`endif

   lsu_load_extend u_extend (
      .asm_i  (asm_q),
      .code_i (ctrl_q),
      .data_o (extData)
   );

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      wr_d           = wr_q;
      ctrl_d         = ctrl_q;
      n_d            = n_q;
      idx_d          = idx_q;
      asm_d          = asm_q;
      err_d          = err_q;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = 8'h00;
      case (state_q)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               addr_d  = bus.req_addr[MEM_AW-1:0];
               wdata_d = bus.req_wdata;
               wr_d    = bus.req_DMWR;
               ctrl_d  = bus.req_DMCtrl;
               n_d     = reqN;
               idx_d   = 2'd0;
               asm_d   = 32'h0;
               err_d   = reqErr;
               state_d = reqErr ? ST_RESP : ST_XFER;
            end
         end
         ST_XFER: begin
            bus.mem_addr = addr_q + MEM_AW'(idx_q);
            if (wr_q) begin
               bus.mem_we    = 1'b1;
               bus.mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
            end else begin
               asm_d[{idx_q, 3'b000} +: 8] = bus.mem_rdata;
            end
            idx_d = idx_q + 2'd1;
            if ({1'b0, idx_q} == n_q - 3'd1) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Only completed loads carry data; stores, errors and idle cycles read as zero.
   assign bus.resp_data = (state_q == ST_RESP && !err_q && !wr_q) ? extData : 32'h0;
   assign bus.resp_err  = (state_q == ST_RESP) && err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         wr_q    <= 1'b0;
         ctrl_q  <= 3'b000;
         n_q     <= 3'd0;
         idx_q   <= 2'd0;
         asm_q   <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         ctrl_q  <= ctrl_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         asm_q   <= asm_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed plus randomized checks of lsu_byte_sequencer against a byte-array reference model.
module tb_lsu_byte_sequencer;

   localparam int MEM_DEPTH = 21;
   localparam int MEM_AW    = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   lsu_byte_sequencer_if #(.MEM_AW(MEM_AW)) bus();

   lsu_byte_sequencer #(.MEM_DEPTH(MEM_DEPTH), .MEM_AW(MEM_AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem [0:31];
   logic       pokeEn = 1'b0;
   logic [4:0] pokeAddr = 5'd0;
   logic [7:0] pokeData = 8'h00;
   int         weCount = 0;

   // Byte memory seen by the DUT; the bench preloads it through the poke port.
   always @(posedge clk) begin
      if (pokeEn) mem[pokeAddr] <= pokeData;
      else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
   end

   always @(posedge clk) begin
      if (bus.mem_we) weCount <= weCount + 1;
   end

   assign bus.mem_rdata = mem[bus.mem_addr];

   logic [7:0]  refMem [0:MEM_DEPTH-1];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] lastData;
   logic        lastErr;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pokeByte(input int addr, input logic [7:0] data);
      pokeEn   = 1'b1;
      pokeAddr = 5'(addr);
      pokeData = data;
      refMem[addr] = data;
      @(negedge clk);
      pokeEn = 1'b0;
   endtask

   // Reference model: decides outcome from size, direction and byte range, then updates refMem.
   task automatic modelRequest(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                               input logic [2:0] ctrl, output logic expErr,
                               output logic [31:0] expData, output int expLat, output int expWe);
      int          n;
      logic [31:0] raw;
      case (ctrl)
         3'd0, 3'd4: n = 1;
         3'd1, 3'd5: n = 2;
         3'd2:       n = 4;
         default:    n = 0;
      endcase
      expErr = (n == 0) || (wr && ctrl[2]);
`ifdef LSU_MISALIGN_TRAP_EN
      if (n == 2 && addr[0]) expErr = 1'b1;
      if (n == 4 && addr[1:0] != 2'b00) expErr = 1'b1;
`endif
      if (longint'(addr) + longint'(n) - 1 >= longint'(MEM_DEPTH)) expErr = 1'b1;
      raw = 32'h0;
      expData = 32'h0;
      if (!expErr) begin
         for (int i = 0; i < n; i++) begin
            if (wr) refMem[int'(addr) + i] = wdata[8*i +: 8];
            else raw = raw | (32'(refMem[int'(addr) + i]) << (8 * i));
         end
         if (!wr) begin
            case (ctrl)
               3'd0:    expData = (raw >= 32'd128)   ? raw - 32'd256   : raw;
               3'd1:    expData = (raw >= 32'd32768) ? raw - 32'd65536 : raw;
               default: expData = raw;
            endcase
         end
      end
      expLat = expErr ? 1 : n + 1;
      expWe  = (wr && !expErr) ? n : 0;
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                                input logic [2:0] ctrl, input int hold);
      logic        expErr;
      logic [31:0] expData;
      int          expLat, expWe, weStart, lat, bad;
      modelRequest(addr, wdata, wr, ctrl, expErr, expData, expLat, expWe);
      weStart        = weCount;
      bus.req_valid  = 1'b1;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_DMWR   = wr;
      bus.req_DMCtrl = ctrl;
      checkOutput("req_ready_idle", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      while (bus.resp_valid !== 1'b1 && lat < 12) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput("latency", 32'(lat), 32'(expLat));
      checkOutput("resp_err", 32'(bus.resp_err), 32'(expErr));
      checkOutput("resp_data", bus.resp_data, expData);
      lastData = bus.resp_data;
      lastErr  = bus.resp_err;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("hold_valid", 32'(bus.resp_valid), 32'd1);
         checkOutput("hold_data", bus.resp_data, expData);
         checkOutput("hold_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready = 1'b0;
      checkOutput("retire_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("retire_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("we_cycles", 32'(weCount - weStart), 32'(expWe));
      bad = 0;
      for (int i = 0; i < MEM_DEPTH; i++) if (mem[i] !== refMem[i]) bad++;
      checkOutput("mem_contents", 32'(bad), 32'd0);
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.req_DMWR   = 1'b0;
      bus.req_DMCtrl = 3'b000;
      bus.resp_ready = 1'b0;
      #1 rst = 1'b1;
      #2;
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("rst_resp_err", 32'(bus.resp_err), 32'd0);
      checkOutput("rst_resp_data", bus.resp_data, 32'h0);
      checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
      checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      checkOutput("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) pokeByte(i, 8'($urandom));

      $display("[TB] store word");
      applyStimulus(32'd4, 32'hDEADBEEF, 1'b1, 3'b010, 0);
      checkOutput("sw_bytes", {mem[7], mem[6], mem[5], mem[4]}, 32'hDEADBEEF);
      checkOutput("sw_data", lastData, 32'h0);

      $display("[TB] signed and unsigned byte loads");
      pokeByte(9, 8'h80);
      applyStimulus(32'd9, 32'h0, 1'b0, 3'b000, 0);
      checkOutput("lb_value", lastData, 32'hFFFFFF80);
      applyStimulus(32'd9, 32'h0, 1'b0, 3'b100, 0);
      checkOutput("lbu_value", lastData, 32'h00000080);

      $display("[TB] misaligned halfword");
      pokeByte(19, 8'h34);
      pokeByte(20, 8'h92);
      applyStimulus(32'd19, 32'h0, 1'b0, 3'b001, 1);
`ifdef LSU_MISALIGN_TRAP_EN
      checkOutput("lh_mis_err", 32'(lastErr), 32'd1);
      checkOutput("lh_mis_data", lastData, 32'h0);
`else
      checkOutput("lh_mis_err", 32'(lastErr), 32'd0);
      checkOutput("lh_mis_data", lastData, 32'hFFFF9234);
`endif

      $display("[TB] range, wrap and code errors");
      applyStimulus(32'd18, 32'h0, 1'b0, 3'b010, 0);
      checkOutput("lw_range_err", 32'(lastErr), 32'd1);
      applyStimulus(32'hFFFFFFFE, 32'h12345678, 1'b1, 3'b010, 0);
      checkOutput("sw_wrap_err", 32'(lastErr), 32'd1);
      applyStimulus(32'd3, 32'h000000AA, 1'b1, 3'b100, 0);
      checkOutput("sbu_code_err", 32'(lastErr), 32'd1);
      applyStimulus(32'd20, 32'h0, 1'b0, 3'b000, 0);
      checkOutput("lb_last_ok", 32'(lastErr), 32'd0);

      $display("[TB] backpressure");
      applyStimulus(32'd0, 32'h0, 1'b0, 3'b010, 5);

      $display("[TB] reset during store");
      for (int i = 0; i < 4; i++) pokeByte(i, 8'hAA);
      bus.req_valid  = 1'b1;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'h44332211;
      bus.req_DMWR   = 1'b1;
      bus.req_DMCtrl = 3'b010;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("mid_we_before", 32'(bus.mem_we), 32'd1);
      #1 rst = 1'b1;
      #1;
      checkOutput("mid_we_after", 32'(bus.mem_we), 32'd0);
      checkOutput("mid_req_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("mid_resp_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("mid_mem_addr", 32'(bus.mem_addr), 32'd0);
      checkOutput("mid_bytes", {mem[3], mem[2], mem[1], mem[0]}, 32'hAAAAAA11);
      refMem[0] = 8'h11;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("post_rst_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("post_rst_ready", 32'(bus.req_ready), 32'd1);

      $display("[TB] random requests");
      for (int t = 0; t < 60; t++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 24));
         applyStimulus(a, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
